// File: rtl/gf2m163_reduce_seq.sv
// rtl/gf2m163_reduce_seq.sv - sequential reduction of a 326-bit carry-less product modulo x^163+x^7+x^6+x^3+1
module gf2m163_reduce_seq #(
    parameter int FOLD_W = 41
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [325:0] c_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [162:0] r_out,
    output logic         busy
);

    localparam int N_FOLD = (163 + FOLD_W - 1) / FOLD_W;
    localparam int CW     = $clog2(N_FOLD + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [325:0]   acc;
    logic [325:0]   mask;
    logic [325:0]   win;
    logic [325:0]   acc_fold;
    logic [8:0]     top;
    logic [8:0]     lo;
    logic [8:0]     top_dec;
    logic [CW-1:0]  cnt;
    logic           last_fold;

    assign last_fold = (cnt == CW'(N_FOLD - 1));

    // Bits at or above top are already zero, so the window is simply every bit from lo upward.
    // Its contributions land at or below top-157, strictly beneath lo, so one parallel XOR suffices.
    always_comb begin
        top_dec  = top - 9'(FOLD_W);
        lo       = (top_dec > 9'd163) ? top_dec : 9'd163;
        mask     = {326{1'b1}} << lo;
        win      = acc & mask;
        acc_fold = (acc & ~mask) ^ (win >> 163) ^ (win >> 160) ^ (win >> 157) ^ (win >> 156);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = FOLD;
            FOLD:    if (last_fold) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == FOLD) || (state == DONE);
        r_out     = (state == DONE) ? acc[162:0] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
            cnt <= '0;
            top <= 9'd326;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc <= c_in;
                        cnt <= '0;
                        top <= 9'd326;
                    end
                end
                FOLD: begin
                    acc <= acc_fold;
                    top <= lo;
                    cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gf2m163_reduce_seq.sv
// tb/tb_gf2m163_reduce_seq.sv - directed and model-based bench for gf2m163_reduce_seq at FOLD_W 41, 1 and 156
module tb_gf2m163_reduce_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   in_valid;
    logic [2:0]   in_ready;
    logic [325:0] c_in;
    logic [2:0]   out_valid;
    logic         out_ready;
    logic [162:0] r_out [3];
    logic [2:0]   busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gf2m163_reduce_seq #(.FOLD_W(41)) u_w41 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .c_in(c_in),
        .out_valid(out_valid[0]), .out_ready(out_ready), .r_out(r_out[0]), .busy(busy[0])
    );
    gf2m163_reduce_seq #(.FOLD_W(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .c_in(c_in),
        .out_valid(out_valid[1]), .out_ready(out_ready), .r_out(r_out[1]), .busy(busy[1])
    );
    gf2m163_reduce_seq #(.FOLD_W(156)) u_w156 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .c_in(c_in),
        .out_valid(out_valid[2]), .out_ready(out_ready), .r_out(r_out[2]), .busy(busy[2])
    );

    function automatic logic [162:0] ref_reduce(input logic [325:0] c);
        logic [325:0] a;
        a = c;
        for (int k = 325; k >= 163; k--) begin
            if (a[k]) begin
                a[k]       = 1'b0;
                a[k - 163] = ~a[k - 163];
                a[k - 160] = ~a[k - 160];
                a[k - 157] = ~a[k - 157];
                a[k - 156] = ~a[k - 156];
            end
        end
        return a[162:0];
    endfunction

    function automatic logic [325:0] rnd326();
        logic [351:0] r;
        for (int i = 0; i < 11; i++) r[i*32 +: 32] = $urandom;
        return r[325:0];
    endfunction

    task automatic chk(input string tag, input logic [325:0] obs, input logic [325:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input int sel, input logic [325:0] v, input logic [162:0] exp,
                       input int lat_exp, input bit stall);
        int lat;
        logic [162:0] held;
        chk("in_ready_before_accept", 326'(in_ready[sel]), 326'(1));
        c_in = v;
        in_valid[sel] = 1'b1;
        @(posedge clk); #1;
        in_valid[sel] = 1'b0;
        c_in = rnd326();
        chk("busy_after_accept", 326'(busy[sel]), 326'(1));
        chk("in_ready_in_fold", 326'(in_ready[sel]), 326'(0));
        lat = 0;
        while (!out_valid[sel] && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 326'(lat), 326'(lat_exp));
        chk("r_out", 326'(r_out[sel]), 326'(exp));
        if (stall) begin
            held = r_out[sel];
            in_valid[sel] = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                chk("stall_out_valid", 326'(out_valid[sel]), 326'(1));
                chk("stall_r_out", 326'(r_out[sel]), 326'(held));
                chk("stall_in_ready", 326'(in_ready[sel]), 326'(0));
            end
            in_valid[sel] = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_after_drain", 326'(out_valid[sel]), 326'(0));
        chk("in_ready_after_drain", 326'(in_ready[sel]), 326'(1));
        chk("busy_after_drain", 326'(busy[sel]), 326'(0));
        chk("r_out_idle", 326'(r_out[sel]), 326'(0));
    endtask

    initial begin
        logic [325:0] v;
        logic [162:0] e;

        rst = 1'b0;
        in_valid = '0;
        out_ready = 1'b0;
        c_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 326'(out_valid), 326'(0));
        chk("reset_busy", 326'(busy), 326'(0));
        chk("reset_r_out", 326'(r_out[0]), 326'(0));
        chk("reset_in_ready", 326'(in_ready), 326'(3'b111));
        rst = 1'b1;
        @(posedge clk); #1;

        run(0, 326'(0), 163'(0), 4, 1'b0);
        v = '0; v[163] = 1'b1;
        run(0, v, 163'h0C9, 4, 1'b0);
        v = '0; v[325] = 1'b1;
        e = '0; e[162] = 1'b1; e[15:0] = 16'h2844;
        run(0, v, e, 4, 1'b0);
        run(0, 326'h1234, 163'h1234, 4, 1'b0);
        v = '1;
        run(0, v, ref_reduce(v), 4, 1'b0);

        for (int i = 0; i < 4; i++) begin
            v = rnd326();
            run(0, v, ref_reduce(v), 4, 1'b0);
            v = rnd326();
            run(1, v, ref_reduce(v), 163, 1'b0);
            v = rnd326();
            run(2, v, ref_reduce(v), 2, 1'b0);
        end
        v = '0; v[325] = 1'b1;
        run(1, v, e, 163, 1'b0);
        run(2, v, e, 2, 1'b0);

        v = rnd326();
        run(0, v, ref_reduce(v), 4, 1'b1);

        c_in = rnd326();
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("abort_out_valid", 326'(out_valid[0]), 326'(0));
        chk("abort_busy", 326'(busy[0]), 326'(0));
        chk("abort_r_out", 326'(r_out[0]), 326'(0));
        chk("abort_in_ready", 326'(in_ready[0]), 326'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        v = rnd326();
        run(0, v, ref_reduce(v), 4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
